// File: rtl/divisor_sequencial_pkg.sv
// Shared constants and FSM state encoding for the sequential 32/16 restoring divider.
package divisor_sequencial_pkg;

  localparam int unsigned DIVIDEND_W = 32;
  localparam int unsigned DIVISOR_W  = 16;
  localparam int unsigned N_ITER     = 16;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/divisor_sequencial_subtrator.sv
// 17-bit combinational compare/subtract used by both the overflow check and each division step.
module subtrator
  import divisor_sequencial_pkg::*;
(
  input  logic [DIVISOR_W:0] Minuendo,
  input  logic [DIVISOR_W:0] Subtraendo,
  output logic [DIVISOR_W:0] Diferenca,
  output logic               Maior_igual
);

  assign Diferenca   = Minuendo - Subtraendo;
  assign Maior_igual = (Minuendo >= Subtraendo);

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential unsigned divider: 32-bit dividend / 16-bit divisor, one quotient bit per RUN cycle.
module divisor_sequencial
  import divisor_sequencial_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  St,
  input  logic [DIVIDEND_W-1:0] Dividendo,
  input  logic [DIVISOR_W-1:0]  Divisor,
  output logic [DIVISOR_W-1:0]  Quociente,
  output logic [DIVISOR_W-1:0]  Resto,
  output logic                  Overflow,
  output logic                  Idle,
  output logic                  Done
);

  state_t                state_q, state_d;
  logic [DIVIDEND_W:0]   acc_q, acc_d;
  logic [DIVISOR_W-1:0]  dreg_q, dreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [DIVISOR_W:0]    sub_a, sub_diff;
  logic                  sub_ge;

  // acc_q MSB is always 0 while in CHECK, so it serves as the zero-extension bit there.
  assign sub_a = (state_q == CHECK) ? {acc_q[DIVIDEND_W], acc_q[DIVIDEND_W-1:DIVISOR_W]}
                                    : acc_q[DIVIDEND_W-1:DIVISOR_W-1];

  subtrator u_subtrator (
    .Minuendo    (sub_a),
    .Subtraendo  ({1'b0, dreg_q}),
    .Diferenca   (sub_diff),
    .Maior_igual (sub_ge)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dreg_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dreg_q  <= dreg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dreg_d  = dreg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (St) begin
          acc_d   = {1'b0, Dividendo};
          dreg_d  = Divisor;
          ovf_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (sub_ge) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sub_ge) acc_d = {sub_diff, acc_q[DIVISOR_W-2:0], 1'b1};
        else        acc_d = {acc_q[DIVIDEND_W-1:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_ITER - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Quociente = acc_q[DIVISOR_W-1:0];
  assign Resto     = acc_q[DIVIDEND_W-1:DIVISOR_W];
  assign Overflow  = ovf_q;
  assign Idle      = (state_q == IDLE);
  assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench: directed corner cases plus randomized divisions against an arithmetic model.
module tb_divisor_sequencial;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        St;
  logic [31:0] Dividendo;
  logic [15:0] Divisor;
  logic [15:0] Quociente;
  logic [15:0] Resto;
  logic        Overflow;
  logic        Idle;
  logic        Done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 Clk = ~Clk;

  divisor_sequencial dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .St        (St),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .Overflow  (Overflow),
    .Idle      (Idle),
    .Done      (Done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic; overflow when quotient exceeds 16 bits or divisor is zero.
  function automatic void model(input logic [31:0] dd, input logic [15:0] dv,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic ovf);
    longint unsigned qq;
    longint unsigned rr;
    if (dv == 16'd0) begin
      ovf = 1'b1;
    end else begin
      qq  = longint'(dd) / longint'(dv);
      ovf = (qq > 65535);
    end
    if (ovf) begin
      q = dd[15:0];
      r = dd[31:16];
    end else begin
      qq = longint'(dd) / longint'(dv);
      rr = longint'(dd) % longint'(dv);
      q  = 16'(qq);
      r  = 16'(rr);
    end
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, ".idle"}, 32'(Idle), 32'd1);
    check({tag, ".done"}, 32'(Done), 32'd0);
    check({tag, ".q"},    32'(Quociente), 32'd0);
    check({tag, ".r"},    32'(Resto), 32'd0);
    check({tag, ".ovf"},  32'(Overflow), 32'd0);
  endtask

  task automatic do_op(input logic [31:0] dd, input logic [15:0] dv, input bit perturb, input string tag);
    logic [15:0] eq, er;
    logic        eo;
    int unsigned cyc, busy_idle;
    model(dd, dv, eq, er, eo);
    @(negedge Clk);
    St = 1'b1; Dividendo = dd; Divisor = dv;
    @(negedge Clk);
    St = 1'b0; cyc = 1; busy_idle = 0;
    while (!Done && cyc < 40) begin
      if (Idle) busy_idle++;
      if (perturb) begin
        St        = 1'($urandom_range(0, 1));
        Dividendo = $urandom;
        Divisor   = 16'($urandom);
      end
      @(negedge Clk);
      cyc++;
    end
    St = 1'b0;
    check({tag, ".lat"},  32'(cyc), eo ? 32'd2 : 32'd18);
    check({tag, ".busy"}, 32'(busy_idle), 32'd0);
    check({tag, ".q"},    32'(Quociente), 32'(eq));
    check({tag, ".r"},    32'(Resto), 32'(er));
    check({tag, ".ovf"},  32'(Overflow), 32'(eo));
    @(negedge Clk);
    check({tag, ".idle"}, 32'(Idle), 32'd1);
    check({tag, ".done1"}, 32'(Done), 32'd0);
    check({tag, ".qhold"}, 32'(Quociente), 32'(eq));
    check({tag, ".rhold"}, 32'(Resto), 32'(er));
    check({tag, ".ohold"}, 32'(Overflow), 32'(eo));
  endtask

  initial begin
    logic [31:0] dd;
    logic [15:0] dv;
    int unsigned done_seen;
    int          pulses[$];

    Reset = 1'b1; St = 1'b0; Dividendo = '0; Divisor = '0;
    repeat (2) @(negedge Clk);
    check_reset_state("rst");
    Reset = 1'b0;

    do_op(32'd100, 16'd7, 1'b0, "norm");
    do_op(32'hFFFE0001, 16'hFFFF, 1'b0, "max");
    do_op(32'h00010000, 16'd1, 1'b0, "ovf");
    do_op(32'd5, 16'd0, 1'b0, "div0");

    // Reset in IDLE clears held overflow result.
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    check_reset_state("rst_idle");

    // Abort in the 8th RUN cycle (cycle 9 after the start edge).
    @(negedge Clk);
    St = 1'b1; Dividendo = 32'd100; Divisor = 16'd7;
    @(negedge Clk);
    St = 1'b0;
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_reset_state("abort");
    done_seen = 0;
    repeat (25) begin
      @(negedge Clk);
      if (Done) done_seen++;
    end
    check("abort.nodone", 32'(done_seen), 32'd0);
    do_op(32'd100, 16'd7, 1'b0, "after_abort");

    do_op(32'd100, 16'd7, 1'b1, "pert_a");
    do_op(32'd1000000, 16'd300, 1'b1, "pert_b");

    // St held high: pulses at cycles 18, 37, 56.
    @(negedge Clk);
    St = 1'b1; Dividendo = 32'd100; Divisor = 16'd7;
    for (int c = 1; c <= 70 && pulses.size() < 3; c++) begin
      @(negedge Clk);
      if (Done) begin
        pulses.push_back(c);
        check("b2b.q", 32'(Quociente), 32'd14);
        check("b2b.r", 32'(Resto), 32'd2);
      end
    end
    St = 1'b0;
    check("b2b.count", 32'(pulses.size()), 32'd3);
    if (pulses.size() >= 1) check("b2b.first", 32'(pulses[0]), 32'd18);
    if (pulses.size() >= 2) check("b2b.gap1", 32'(pulses[1] - pulses[0]), 32'd19);
    if (pulses.size() >= 3) check("b2b.gap2", 32'(pulses[2] - pulses[1]), 32'd19);
    @(negedge Clk);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          dv = 16'($urandom_range(0, 3));
          dd = $urandom;
        end
        1: begin
          dv = 16'($urandom);
          if (dv == 16'd0) dv = 16'd1;
          dd = {16'($urandom % dv), 16'($urandom)};
        end
        2: begin
          dv = 16'($urandom_range(1, 255));
          dd = $urandom_range(0, 1 << 20);
        end
        default: begin
          dv = 16'($urandom);
          dd = $urandom;
        end
      endcase
      do_op(dd, dv, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divisor_sequencial.md
DIVISOR_SEQUENCIAL -- requirements
Module: divisor_sequencial

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port St, input, 1 bit: start request, sampled only in IDLE.
REQ-004 SHALL have port Dividendo, input, 32 bits: unsigned dividend, captured on the start edge.
REQ-005 SHALL have port Divisor, input, 16 bits: unsigned divisor, captured on the start edge.
REQ-006 SHALL have port Quociente, output, 16 bits: quotient, equal to ACC[15:0].
REQ-007 SHALL have port Resto, output, 16 bits: remainder, equal to ACC[31:16].
REQ-008 SHALL have port Overflow, output, 1 bit: quotient does not fit in 16 bits, or divide by zero.
REQ-009 SHALL have port Idle, output, 1 bit: high only in state IDLE.
REQ-010 SHALL have port Done, output, 1 bit: high only in state DONE, for exactly one cycle.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, CHECK, RUN, DONE.
REQ-012 IDLE with St=1: on that edge, SHALL load ACC[32:0] <= {1'b0, Dividendo}, latch Divisor into DREG, clear Overflow, and go to CHECK.
REQ-013 IDLE with St=0: SHALL remain in IDLE with ACC, DREG and Overflow held.
REQ-014 CHECK: if ACC[31:16] >= DREG (including DREG=0), SHALL set Overflow=1, leave ACC unchanged and go to DONE; otherwise SHALL clear the counter and go to RUN.
REQ-015 RUN, each cycle: T = {ACC[31:0],1'b0}; if T[32:16] >= {1'b0,DREG}, SHALL set ACC <= {T[32:16]-DREG, T[15:1], 1'b1}; else ACC <= T.
REQ-016 RUN SHALL iterate exactly 16 times, counted by a 4-bit counter, and go to DONE on the 16th iteration edge.
REQ-017 DONE SHALL go to IDLE unconditionally on the next edge; St SHALL be ignored in CHECK, RUN and DONE.
REQ-018 Latency SHALL be: Done high in the 18th cycle after the St-sampling edge for normal division, and in the 2nd cycle for overflow.
REQ-019 Result SHALL be Quociente = floor(Dividendo/Divisor) and Resto = Dividendo mod Divisor when Overflow=0, all arithmetic unsigned.
REQ-020 On overflow, SHALL output Quociente = Dividendo[15:0] and Resto = Dividendo[31:16], since ACC is unchanged.
REQ-021 Quociente, Resto and Overflow SHALL hold their values from DONE until the next accepted St.
REQ-022 Back-to-back operation: St held high SHALL start a new operation on the first IDLE cycle after DONE, giving a minimum period of 19 cycles.
REQ-023 Inputs SHALL NOT affect the result after the start edge.

Reset
REQ-024 Reset=1 at an edge SHALL force state IDLE, ACC=0, DREG=0, counter=0 and Overflow=0, giving Idle=1, Done=0, Quociente=0, Resto=0.
REQ-025 Reset SHALL take priority over St and SHALL abort any operation in CHECK, RUN or DONE; no Done pulse SHALL follow.

Structure
REQ-026 The shared package SHALL hold the state encoding (IDLE, CHECK, RUN, DONE), the width constants (dividend 32, divisor 16, iteration count 16) and the counter width of 4.
REQ-027 The 17-bit compare/subtract SHALL be a combinational sub-module named subtrator, with outputs Diferenca[16:0] and Maior_igual.
REQ-028 FSM, counter and ACC register SHALL reside in divisor_sequencial; no latches, and all registers on Clk.

Verification
REQ-029 Normal division: Dividendo=32'd100, Divisor=16'd7 -> Quociente=14, Resto=2, Overflow=0, Done in the 18th cycle after start.
REQ-030 Maximum values: Dividendo=32'hFFFE0001, Divisor=16'hFFFF -> Quociente=16'hFFFF, Resto=0, Overflow=0.
REQ-031 Overflow: Dividendo=32'h00010000, Divisor=1 -> Overflow=1, Quociente=0, Resto=1, Done in the 2nd cycle after start.
REQ-032 Divide by zero: Dividendo=32'd5, Divisor=0 -> Overflow=1, Quociente=5, Resto=0, Done in the 2nd cycle.
REQ-033 Reset abort: assert Reset in the 8th RUN cycle -> next cycle Idle=1, Done=0, outputs 0; a following 100/7 operation still yields 14 and 2.
REQ-034 St handling: toggle St and change inputs during RUN -> result unaffected; St held high continuously -> next start on the first IDLE cycle and Done pulses 19 cycles apart.
